// File: rtl/matrix_calc_pkg.sv
// Shared constants and types for the matrix calculator control path.
// Both the controller FSM and the countdown timer take their limits from here.
package matrix_calc_pkg;

   localparam int unsigned CD_MIN_SECONDS     = 5;
   localparam int unsigned CD_MAX_SECONDS     = 15;
   localparam int unsigned CD_DEFAULT_SECONDS = 10;

   typedef enum logic {
      CdIdle,
      CdRun
   } cd_state_e;

   typedef logic [3:0] bcd_digit_t;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divide-by-DIV strobe generator, held at zero while disabled.
// Also used by the display refresh logic.
module tick_prescaler #(
   parameter int unsigned DIV = 10
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic tick
);

   localparam int unsigned PW = $clog2(DIV);
   localparam logic [PW-1:0] LAST = PW'(DIV - 1);

   logic [PW-1:0] presc_q, presc_d;

   always_comb begin
      presc_d = '0;
      if (enable && !clear && (presc_q != LAST)) begin
         presc_d = presc_q + 1'b1;
      end
   end

   assign tick = enable && (presc_q == LAST);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         presc_q <= '0;
      end else begin
         presc_q <= presc_d;
      end
   end

endmodule

// File: rtl/countdown_timer.sv
// Programmable seconds countdown with BCD readout; answers the controller's
// start_countdown request with a single-cycle countdown_done pulse.
module countdown_timer
   import matrix_calc_pkg::*;
#(
   parameter int unsigned CLK_FREQ_HZ     = 100_000_000,
   parameter int unsigned TICK_HZ         = 1,
   parameter int unsigned DEFAULT_SECONDS = CD_DEFAULT_SECONDS,
   parameter int unsigned MIN_SECONDS     = CD_MIN_SECONDS,
   parameter int unsigned MAX_SECONDS     = CD_MAX_SECONDS
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start_countdown,
   input  logic       abort,
   input  logic       cfg_valid,
   input  logic [4:0] cfg_seconds,
   output logic       countdown_done,
   output logic       running,
   output logic [3:0] sec_tens,
   output logic [3:0] sec_ones,
   output logic       cfg_error
);

   localparam int unsigned DIV = CLK_FREQ_HZ / TICK_HZ;
   localparam logic [4:0] MIN_LEN = 5'(MIN_SECONDS);
   localparam logic [4:0] MAX_LEN = 5'(MAX_SECONDS);
   localparam logic [4:0] DEF_LEN = 5'(DEFAULT_SECONDS);

   function automatic logic [7:0] bin_to_bcd(input logic [4:0] v);
      logic [4:0] r;
      bcd_digit_t tens;
      r    = v;
      tens = 4'd0;
      if (r >= 5'd30) begin
         tens = 4'd3;
         r    = r - 5'd30;
      end else if (r >= 5'd20) begin
         tens = 4'd2;
         r    = r - 5'd20;
      end else if (r >= 5'd10) begin
         tens = 4'd1;
         r    = r - 5'd10;
      end
      return {tens, 4'(r)};
   endfunction

   cd_state_e  state_q, state_d;
   bcd_digit_t tens_q, tens_d;
   bcd_digit_t ones_q, ones_d;
   logic [4:0] cfg_len_q, cfg_len_d;
   logic       done_q, done_d;
   logic       cfg_err_q, cfg_err_d;
   logic [7:0] load_bcd;
   logic       tick;
   logic       last_second;

   assign load_bcd    = bin_to_bcd(cfg_len_q);
   assign last_second = (tens_q == 4'd0) && (ones_q <= 4'd1);

   tick_prescaler #(
      .DIV (DIV)
   ) u_prescaler (
      .clk    (clk),
      .rst_n  (rst_n),
      .clear  (start_countdown | abort),
      .enable (state_q == CdRun),
      .tick   (tick)
   );

   always_comb begin
      state_d   = state_q;
      tens_d    = tens_q;
      ones_d    = ones_q;
      cfg_len_d = cfg_len_q;
      done_d    = 1'b0;
      cfg_err_d = 1'b0;

      // The load below reads cfg_len_q, so a same-cycle config only affects the next start.
      if (cfg_valid) begin
         if ((cfg_seconds >= MIN_LEN) && (cfg_seconds <= MAX_LEN)) begin
            cfg_len_d = cfg_seconds;
         end else begin
            cfg_err_d = 1'b1;
         end
      end

      case (state_q)
         CdIdle: begin
            if (start_countdown) begin
               {tens_d, ones_d} = load_bcd;
               state_d          = CdRun;
            end
         end
         CdRun: begin
            if (abort) begin
               tens_d  = 4'd0;
               ones_d  = 4'd0;
               state_d = CdIdle;
            end else if (start_countdown) begin
               {tens_d, ones_d} = load_bcd;
            end else if (tick) begin
               if (last_second) begin
                  tens_d  = 4'd0;
                  ones_d  = 4'd0;
                  done_d  = 1'b1;
                  state_d = CdIdle;
               end else if (ones_q == 4'd0) begin
                  ones_d = 4'd9;
                  tens_d = tens_q - 4'd1;
               end else begin
                  ones_d = ones_q - 4'd1;
               end
            end
         end
         default: begin
            state_d = CdIdle;
            tens_d  = 4'd0;
            ones_d  = 4'd0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= CdIdle;
         tens_q    <= 4'd0;
         ones_q    <= 4'd0;
         cfg_len_q <= DEF_LEN;
         done_q    <= 1'b0;
         cfg_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         tens_q    <= tens_d;
         ones_q    <= ones_d;
         cfg_len_q <= cfg_len_d;
         done_q    <= done_d;
         cfg_err_q <= cfg_err_d;
      end
   end

   assign running        = (state_q == CdRun);
   assign sec_tens       = tens_q;
   assign sec_ones       = ones_q;
   assign countdown_done = done_q;
   assign cfg_error      = cfg_err_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Randomized and directed bench for countdown_timer; a time-based reference
// model queues the expected outputs of every edge and a monitor checks them.
`timescale 1ns/1ps
module tb_countdown_timer;

   localparam int DIV = 10;
   localparam int MIN_S = 5;
   localparam int MAX_S = 15;
   localparam int DEF_S = 10;

   typedef struct packed {
      logic       running;
      logic [3:0] tens;
      logic [3:0] ones;
      logic       done;
      logic       err;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic       start_countdown;
   logic       abort;
   logic       cfg_valid;
   logic [4:0] cfg_seconds;
   logic       countdown_done;
   logic       running;
   logic [3:0] sec_tens;
   logic [3:0] sec_ones;
   logic       cfg_error;

   countdown_timer #(
      .CLK_FREQ_HZ (10),
      .TICK_HZ     (1)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .start_countdown (start_countdown),
      .abort           (abort),
      .cfg_valid       (cfg_valid),
      .cfg_seconds     (cfg_seconds),
      .countdown_done  (countdown_done),
      .running         (running),
      .sec_tens        (sec_tens),
      .sec_ones        (sec_ones),
      .cfg_error       (cfg_error)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   exp_t expq[$];
   int   n_checks = 0;
   int   n_fails = 0;

   // Reference model: a countdown is a start edge plus a length; everything
   // else follows from elapsed edges.
   bit m_active = 1'b0;
   int m_t0 = 0;
   int m_n = 0;
   int m_cfg = DEF_S;
   int m_edge = 0;

   task automatic model(input bit s, input bit a, input bit cv, input int cs, input bit rn);
      exp_t x;
      int   rem;
      x = '0;
      if (!rn) begin
         m_active = 1'b0;
         m_cfg    = DEF_S;
      end else begin
         x.err = cv && (cs < MIN_S || cs > MAX_S);
         if (m_active && a) begin
            m_active = 1'b0;
         end else if (s) begin
            m_active = 1'b1;
            m_t0     = m_edge;
            m_n      = m_cfg;
         end else if (m_active && (m_edge - m_t0) == m_n * DIV) begin
            m_active = 1'b0;
            x.done   = 1'b1;
         end
         if (cv && !x.err) m_cfg = cs;
         rem       = m_active ? m_n - (m_edge - m_t0) / DIV : 0;
         x.running = m_active;
         x.tens    = 4'(rem / 10);
         x.ones    = 4'(rem % 10);
      end
      m_edge++;
      expq.push_back(x);
   endtask

   task automatic step(input bit s, input bit a, input bit cv, input int cs, input bit rn);
      @(negedge clk);
      start_countdown = s;
      abort           = a;
      cfg_valid       = cv;
      cfg_seconds     = 5'(cs);
      rst_n           = rn;
      model(s, a, cv, cs, rn);
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 1'b0, 1'b0, 0, 1'b1);
   endtask

   task automatic start();
      step(1'b1, 1'b0, 1'b0, 0, 1'b1);
   endtask

   task automatic cfg(input int cs);
      step(1'b0, 1'b0, 1'b1, cs, 1'b1);
   endtask

   exp_t mon_e;
   exp_t mon_g;
   int   mon_cyc = 0;

   initial begin
      forever begin
         @(posedge clk);
         #1;
         mon_cyc++;
         if (expq.size() > 0) begin
            mon_e = expq.pop_front();
            mon_g = {running, sec_tens, sec_ones, countdown_done, cfg_error};
            n_checks++;
            if (mon_g !== mon_e) begin
               n_fails++;
               if (n_fails <= 25)
                  $display("FAIL outputs cyc=%0d got run=%b bcd=%h%h done=%b err=%b want run=%b bcd=%h%h done=%b err=%b",
                           mon_cyc, mon_g.running, mon_g.tens, mon_g.ones, mon_g.done, mon_g.err,
                           mon_e.running, mon_e.tens, mon_e.ones, mon_e.done, mon_e.err);
            end
         end
      end
   end

   initial begin
      rst_n           = 1'b0;
      start_countdown = 1'b0;
      abort           = 1'b0;
      cfg_valid       = 1'b0;
      cfg_seconds     = '0;

      // Reset then default 10 s run.
      repeat (3) step(1'b0, 1'b0, 1'b0, 0, 1'b0);
      start();
      idle(110);

      // Valid and rejected configuration; same-cycle cfg loads the old length.
      cfg(7);
      start();
      idle(80);
      cfg(3);
      cfg(20);
      step(1'b1, 1'b0, 1'b1, 9, 1'b1);
      idle(80);
      cfg(10);

      // Restart mid-run, and restart exactly on a tick.
      start();
      idle(34);
      start();
      idle(110);
      start();
      idle(9);
      start();
      idle(105);

      // Abort, abort ignored in idle with start winning, abort with start in RUN.
      start();
      idle(49);
      step(1'b0, 1'b1, 1'b0, 0, 1'b1);
      idle(8);
      step(1'b1, 1'b1, 1'b0, 0, 1'b1);
      idle(5);
      step(1'b1, 1'b1, 1'b0, 0, 1'b1);
      idle(5);

      // Reset mid-count restores the default length.
      cfg(7);
      start();
      idle(39);
      step(1'b0, 1'b0, 1'b0, 0, 1'b0);
      idle(2);
      start();
      idle(105);

      // Config change during run affects only the next start.
      start();
      idle(19);
      cfg(12);
      idle(85);
      start();
      idle(125);

      // Start held for several cycles.
      repeat (4) start();
      idle(5);
      step(1'b0, 1'b1, 1'b0, 0, 1'b1);
      idle(3);

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 39) == 0, $urandom_range(0, 59) == 0,
              $urandom_range(0, 29) == 0, int'($urandom_range(0, 31)),
              $urandom_range(0, 499) != 0);
      end
      idle(5);

      repeat (4) @(posedge clk);
      #2;
      n_checks++;
      if (expq.size() != 0) begin
         n_fails++;
         $display("FAIL drain got %0d pending want 0", expq.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
